// File: rtl/shreg_ctrl_pkg.sv
// shreg_ctrl_pkg
//   Shared definitions for the tapped delay-line controller:
//   - state_e  : controller state encoding
//   - calc_lw  : ceil(log2(n)), never less than 1, used for tap/occupancy widths
package shreg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  function automatic int unsigned calc_lw(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/shreg_tap.sv
// shreg_tap
//   Plain shift register with a variable read tap. No reset and no initial
//   value on the stages so the line can map onto shift-register primitives.
// Ports
//   clk : clock
//   en  : shift enable; stage k -> k+1, d -> stage 0
//   d   : input sample
//   tap : stage index driven onto q
//   q   : stage[tap], combinational
module shreg_tap
  import shreg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 130,
  localparam int unsigned LW = calc_lw(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [LW-1:0]    tap,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      stage_q[0] <= d;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q = stage_q[tap];

endmodule

// File: rtl/shreg_delay_ctrl.sv
// shreg_delay_ctrl
//   Controller for a configurable-length delay line. Tracks how many samples
//   have been shifted in (occ, saturating at DEPTH) against the selected tap
//   (len) and flags q as valid once the tap stage holds a real sample.
// Ports
//   clk, r_n        : clock, synchronous active-low reset
//   i, i_vld, i_rdy : input sample handshake (shift on i_vld && i_rdy)
//   q, q_vld        : delayed sample at stage[len], valid in RUN
//   cfg_vld/cfg_len : tap-length load request; cfg_err pulses on rejection
//   flush           : drop all history
//   busy            : high in FILL or FLUSH
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no samples held (occ == 0)
// ST_FILL  | some samples held, tap not reached (0 < occ <= len)
// ST_RUN   | tap stage holds a real sample (occ > len)
// ST_FLUSH | one-cycle history discard, then EMPTY
module shreg_delay_ctrl
  import shreg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 130,
  localparam int unsigned LW = calc_lw(DEPTH)
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic [WIDTH-1:0] i,
  input  logic             i_vld,
  output logic             i_rdy,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  input  logic             cfg_vld,
  input  logic [LW-1:0]    cfg_len,
  output logic             cfg_err,
  input  logic             flush,
  output logic             busy
);

  localparam int unsigned OW = calc_lw(DEPTH + 1);
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
  localparam logic [LW:0]   DEPTH_X = (LW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [LW-1:0] len_q, len_d;
  logic          cfg_err_q, cfg_err_d;

  logic shift;
  logic cfg_blocked;
  logic cfg_in_range;

  assign i_rdy        = r_n && !flush && (state_q != ST_FLUSH);
  assign shift        = i_vld && i_rdy;
  // Config requests during a flush are silently dropped, not errored.
  assign cfg_blocked  = flush || (state_q == ST_FLUSH);
  assign cfg_in_range = ({1'b0, cfg_len} < DEPTH_X);

  always_ff @(posedge clk) begin
    if (!r_n) begin
      state_q   <= ST_EMPTY;
      occ_q     <= '0;
      len_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;
    if (flush) begin
      occ_d   = '0;
      state_d = ST_FLUSH;
    end else begin
      if (shift && (occ_q != OCC_MAX)) occ_d = occ_q + OW'(1);
      if (cfg_vld && !cfg_blocked) begin
        if (cfg_in_range) len_d = cfg_len;
        else              cfg_err_d = 1'b1;
      end
      // State follows the post-edge occ and len so a same-cycle shift and
      // config change are both reflected.
      if (state_q == ST_FLUSH)          state_d = ST_EMPTY;
      else if (occ_d == '0)             state_d = ST_EMPTY;
      else if (occ_d <= OW'(len_d))     state_d = ST_FILL;
      else                              state_d = ST_RUN;
    end
  end

  assign q_vld   = (state_q == ST_RUN);
  assign busy    = (state_q == ST_FILL) || (state_q == ST_FLUSH);
  assign cfg_err = cfg_err_q;

  shreg_tap #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tap (
    .clk (clk),
    .en  (shift),
    .d   (i),
    .tap (len_q),
    .q   (q)
  );

endmodule

// File: tb/tb_shreg_delay_ctrl.sv
module tb_shreg_delay_ctrl;

  localparam int W  = 8;
  localparam int D  = 130;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          r_n, i_vld, i_rdy, q_vld, cfg_vld, cfg_err, flush, busy;
  logic [W-1:0]  din, q;
  logic [LW-1:0] cfg_len;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shreg_delay_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .r_n     (r_n),
    .i       (din),
    .i_vld   (i_vld),
    .i_rdy   (i_rdy),
    .q       (q),
    .q_vld   (q_vld),
    .cfg_vld (cfg_vld),
    .cfg_len (cfg_len),
    .cfg_err (cfg_err),
    .flush   (flush),
    .busy    (busy)
  );

  typedef struct {
    logic       rn, fl, cv;
    logic [7:0] cl;
    logic       iv;
    logic [7:0] d;
    logic       e_rdy, e_vld, e_busy, e_err, chk_q;
    logic [7:0] e_q;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] hist[$];
  logic [7:0] sb[$];
  int         occ_m, len_m;

  function automatic vec_t mk(logic rn, logic fl, logic cv, logic [7:0] cl,
                              logic iv, logic [7:0] d, logic e_rdy, logic e_vld,
                              logic e_busy, logic e_err, logic chk_q, logic [7:0] e_q);
    vec_t v;
    v.rn = rn; v.fl = fl; v.cv = cv; v.cl = cl; v.iv = iv; v.d = d;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_busy = e_busy; v.e_err = e_err;
    v.chk_q = chk_q; v.e_q = e_q;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    r_n = 1'b1; flush = 1'b0; cfg_vld = 1'b0; cfg_len = '0; i_vld = 1'b0; din = '0;
  endtask

  // Clock one edge with the current inputs, return to idle inputs, then
  // settle at the falling edge for sampling.
  task automatic step();
    @(posedge clk); #1;
    idle();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    logic ev;
    ev = (occ_m > len_m);
    chk({tag, "_vld"}, q_vld, ev);
    chk({tag, "_busy"}, busy, (occ_m > 0) && !ev);
    if (ev) chk({tag, "_q"}, q, hist[len_m]);
  endtask

  task automatic do_shift(input logic [7:0] d, input string tag);
    din = d; i_vld = 1'b1;
    step();
    hist.push_front(d);
    if (hist.size() > D) void'(hist.pop_back());
    occ_m = (occ_m < D) ? occ_m + 1 : D;
    chk_model(tag);
  endtask

  initial begin
    idle();
    r_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //          rn fl cv cl     iv d      rdy vld bsy err cq  q
    tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'h00, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'd3,   0, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h01, 1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h02, 1, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h03, 1, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h04, 1, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h05, 1, 1, 0, 0, 1, 8'h01));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h06, 1, 1, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 1, 0, 0, 1, 8'h03));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 1, 0, 0, 1, 8'h03));
    tbl.push_back(mk(1, 0, 1, 8'd130, 0, 8'h00, 1, 1, 0, 0, 1, 8'h03));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 1, 0, 1, 1, 8'h03));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 1, 0, 0, 1, 8'h03));
    tbl.push_back(mk(1, 1, 1, 8'd1,   1, 8'hAA, 0, 1, 0, 0, 1, 8'h03));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h11, 1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h12, 1, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h13, 1, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'h14, 1, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 1, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 1, 8'd0,   1, 8'h15, 1, 1, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 1, 0, 0, 1, 8'h15));
    tbl.push_back(mk(1, 1, 1, 8'd200, 0, 8'h00, 0, 1, 0, 0, 1, 8'h15));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'd0,   0, 8'h00, 1, 0, 0, 0, 0, 8'h00));

    for (int k = 0; k < tbl.size(); k++) begin
      r_n = tbl[k].rn; flush = tbl[k].fl; cfg_vld = tbl[k].cv;
      cfg_len = tbl[k].cl; i_vld = tbl[k].iv; din = tbl[k].d;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", k),  i_rdy,   tbl[k].e_rdy);
      chk($sformatf("v%0d_vld", k),  q_vld,   tbl[k].e_vld);
      chk($sformatf("v%0d_busy", k), busy,    tbl[k].e_busy);
      chk($sformatf("v%0d_err", k),  cfg_err, tbl[k].e_err);
      if (tbl[k].chk_q) chk($sformatf("v%0d_q", k), q, tbl[k].e_q);
      @(posedge clk); #1;
    end
    idle();

    // Shrink and grow the tap while holding data.
    flush = 1'b1; step(); step();
    hist.delete(); occ_m = 0;
    cfg_vld = 1'b1; cfg_len = 8'd5; step(); len_m = 5;
    for (int k = 0; k < 10; k++) do_shift(8'h20 + 8'(k), $sformatf("fill%0d", k));
    chk("len5_q", q, 8'h24);
    cfg_vld = 1'b1; cfg_len = 8'd2; step(); len_m = 2;
    chk_model("shrink");
    chk("shrink_q_abs", q, 8'h27);
    cfg_vld = 1'b1; cfg_len = 8'd20; step(); len_m = 20;
    chk_model("grow");
    for (int k = 0; k < 20 && occ_m <= 20; k++)
      do_shift(8'($urandom_range(255)), $sformatf("grow%0d", k));
    chk("grow_done_vld", q_vld, 1'b1);

    // Saturation with the longest tap, scoreboarded.
    flush = 1'b1; step(); step();
    cfg_vld = 1'b1; cfg_len = 8'd129; step();
    sb.delete(); occ_m = 0; len_m = 129;
    for (int k = 0; k < 300; k++) begin
      logic [7:0] d;
      d = 8'($urandom_range(255));
      din = d; i_vld = 1'b1;
      step();
      sb.push_back(d);
      occ_m = (occ_m < D) ? occ_m + 1 : D;
      chk($sformatf("sat_vld%0d", k), q_vld, occ_m > len_m);
      if (occ_m > len_m) chk($sformatf("sat_q%0d", k), q, sb.pop_front());
    end
    chk("sat_occ", 32'(dut.occ_q), D);

    // Reset in the middle of RUN.
    r_n = 1'b0;
    @(negedge clk);
    chk("rst_rdy", i_rdy, 1'b0);
    step();
    chk("rst_vld", q_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len", 32'(dut.len_q), 0);
    din = 8'h5A; i_vld = 1'b1; step();
    chk("rst_next_vld", q_vld, 1'b1);
    chk("rst_next_q", q, 8'h5A);
    din = 8'h5B; i_vld = 1'b1; step();
    chk("rst_next2_q", q, 8'h5B);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shreg_delay_ctrl.md
SHREG_DELAY_CTRL -- requirements
Module: shreg_delay_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data bits per sample.
REQ-002 SHALL have parameter DEPTH, default 130: maximum stages in the delay line, legal range 2..256.
REQ-003 SHALL have a derived constant LW = ceil(log2(DEPTH)), the width of the tap index.
REQ-004 SHALL have clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have r_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have i, input, WIDTH: input sample.
REQ-007 SHALL have i_vld, input, 1: the input sample is valid.
REQ-008 SHALL have i_rdy, output, 1: the controller can accept a sample; a sample is accepted (shift) when i_vld && i_rdy.
REQ-009 SHALL have q, output, WIDTH: delayed sample at the current tap.
REQ-010 SHALL have q_vld, output, 1: q holds a real, previously accepted sample.
REQ-011 SHALL have cfg_vld, input, 1: request to load a new tap length.
REQ-012 SHALL have cfg_len, input, LW: requested tap index; the delay is cfg_len+1 shifts.
REQ-013 SHALL have cfg_err, output, 1: one-cycle pulse when a config request is rejected.
REQ-014 SHALL have flush, input, 1: discard all delay-line history.
REQ-015 SHALL have busy, output, 1: high in the FILL or FLUSH state.

Function
REQ-016 SHALL implement a state machine with states EMPTY (occ==0), FILL (0<occ<=len), RUN (occ>len) and FLUSH.
REQ-017 SHALL keep occ, the count of accepted shifts since reset or flush, saturating at DEPTH.
REQ-018 SHALL recompute the next state every cycle from occ_next and len_next; FLUSH always lasts exactly one cycle and is followed by EMPTY.
REQ-019 SHALL, on each accepted shift, move stage k into stage k+1 and load i into stage 0; stages SHALL not change without a shift.
REQ-020 SHALL drive q = stage[len] combinationally and q_vld = (state==RUN).
REQ-021 Latency: the sample accepted at shift n SHALL be on q, with q_vld high, from the cycle after shift n+len until the next shift.
REQ-022 SHALL drive i_rdy = r_n && !flush && (state != FLUSH); i_rdy SHALL not depend on i_vld.
REQ-023 SHALL, when cfg_vld and cfg_len<DEPTH and state!=FLUSH and !flush, load len <= cfg_len at that edge without disturbing stored data or occ.
REQ-024 After a config change q_vld SHALL reflect the new len on the next cycle: shorter len gives RUN immediately if occ>len, longer len may return to FILL.
REQ-025 SHALL, when cfg_vld with cfg_len>=DEPTH, leave len unchanged and pulse cfg_err high for exactly the next cycle.
REQ-026 SHALL also ignore cfg_vld during FLUSH or while flush is high, without raising cfg_err.
REQ-027 When cfg_vld and an accepted shift occur in the same cycle, both SHALL take effect, and the state SHALL be computed from the incremented occ and the new len.
REQ-028 Flush SHALL have priority over cfg_vld and i_vld: occ <= 0, state <= FLUSH, and no sample is accepted that cycle.
REQ-029 When occ==DEPTH, shifts SHALL continue, the oldest sample is lost, and occ SHALL stay at DEPTH.

Reset
REQ-030 While r_n is low at a clock edge, state SHALL become EMPTY, occ 0, len 0 and cfg_err 0; afterwards q_vld=0, busy=0 and i_rdy=0 while r_n is low.
REQ-031 Delay-line data stages SHALL have no reset and no initial value, so the line maps onto shift-register primitives; q is undefined while q_vld is 0.
REQ-032 Reset asserted mid-stream SHALL drop all history, identical in effect to flush.

Structure
REQ-033 Package shreg_ctrl_pkg SHALL hold the state enumeration and the LW-derivation function.
REQ-034 The data path SHALL be sub-module shreg_tap (WIDTH, DEPTH; ports clk, en, d, tap, q), with no reset and a variable read tap.
REQ-035 All control logic (FSM, occ, len, cfg_err) SHALL live in shreg_delay_ctrl.

Verification
REQ-036 Reset then config: after reset, cfg_len=3 is accepted; feed 0x01..0x06 on consecutive cycles -> q_vld first high after the 4th shift with q=0x01, then 0x02, 0x03 on later cycles (WIDTH=8).
REQ-037 Bad config: cfg_len=130 with DEPTH=130 -> cfg_err high one cycle, len unchanged, q and q_vld undisturbed.
REQ-038 Shrink and grow: in RUN with len=5 and occ=10, set cfg_len=2 -> next cycle q=stage[2], q_vld=1; then set cfg_len=20 -> FILL, busy=1, q_vld=0 until occ=21.
REQ-039 Flush collision: flush, i_vld and cfg_vld high together -> i_rdy=0, sample dropped, len unchanged, one FLUSH cycle, then EMPTY with q_vld=0.
REQ-040 Saturation: len=129 with 200 shifts -> occ holds at 130, and q equals the sample accepted 129 shifts earlier.
REQ-041 Reset mid-RUN: assert r_n=0 for one cycle -> q_vld=0, len=0; the next accepted sample appears on q one cycle later with q_vld=1.
